// File: rtl/lock_pkg.sv
// Shared types and helpers for the digital-lock front end: button codes,
// debounce state encoding, and the debounce window length calculation.
package lock_pkg;

   typedef enum logic [1:0] {
      BTN_E = 2'd0,
      BTN_S = 2'd1,
      BTN_W = 2'd2,
      BTN_N = 2'd3
   } btn_e;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } db_state_e;

   localparam int unsigned N_BTN = 4;

   // Debounce window in clock cycles, never shorter than one cycle.
   function automatic int unsigned stable_cycles(input int unsigned clk_freq,
                                                 input int unsigned stable_time);
      int unsigned cycles;
      cycles = (clk_freq * stable_time) / 1000;
      return (cycles < 1) ? 1 : cycles;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-FF synchronizer, debounce FSM with window counter,
// and a one-cycle pulse on the debounced press.
module btn_debounce
   import lock_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 5
)
(
   input  logic clk,
   input  logic rst_n,
   input  logic i_btn,
   output logic o_db,
   output logic o_pulse
);

   localparam int unsigned     CNT_W    = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(STABLE_CYCLES);

   logic             r_s1;
   logic             r_s2;
   db_state_e        r_state;
   db_state_e        w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             r_db;
   logic             w_db_nxt;
   logic             r_pulse;
   logic             w_pulse_nxt;

   assign w_cnt_inc = r_cnt + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1    <= 1'b0;
         r_s2    <= 1'b0;
         r_state <= IDLE;
         r_cnt   <= '0;
         r_db    <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_s1    <= i_btn;
         r_s2    <= r_s1;
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_db    <= w_db_nxt;
         r_pulse <= w_pulse_nxt;
      end
   end

   // The edge that first sees the new level counts as the first stable cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_db_nxt    = r_db;
      w_pulse_nxt = 1'b0;
      case (r_state)
         IDLE, PRESS_WAIT: begin
            if (r_s2) begin
               if (w_cnt_inc == CNT_DONE) begin
                  w_state_nxt = PRESSED;
                  w_cnt_nxt   = '0;
                  w_db_nxt    = 1'b1;
                  w_pulse_nxt = 1'b1;
               end else begin
                  w_state_nxt = PRESS_WAIT;
                  w_cnt_nxt   = w_cnt_inc;
               end
            end else begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end
         end
         PRESSED, RELEASE_WAIT: begin
            if (!r_s2) begin
               if (w_cnt_inc == CNT_DONE) begin
                  w_state_nxt = IDLE;
                  w_cnt_nxt   = '0;
                  w_db_nxt    = 1'b0;
               end else begin
                  w_state_nxt = RELEASE_WAIT;
                  w_cnt_nxt   = w_cnt_inc;
               end
            end else begin
               w_state_nxt = PRESSED;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_db_nxt    = 1'b0;
         end
      endcase
   end

   assign o_db    = r_db;
   assign o_pulse = r_pulse;

endmodule

// File: rtl/btn_conditioner.sv
// Four-button front end for the lock FSM: debounced levels, press pulses and
// a registered priority-encoded event. Define BTN_MULTI_REJECT_EN to reject multi-presses.
module btn_conditioner
   import lock_pkg::*;
#(
   parameter int unsigned CLK_FREQ    = 1024,
   parameter int unsigned STABLE_TIME = 5
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] btn,
   output logic [3:0] btn_db,
   output logic [3:0] btn_pulse,
   output logic       btn_valid,
   output logic [1:0] btn_code,
   output logic       multi_err
);

   localparam int unsigned STABLE_CYCLES = stable_cycles(CLK_FREQ, STABLE_TIME);

   logic [1:0] w_code;
   logic       w_any_pulse;
   logic       w_reject;
   logic       w_accept;
   logic       r_valid;
   logic [1:0] r_code;

   for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
      btn_debounce #(
         .STABLE_CYCLES (STABLE_CYCLES)
      ) u_debounce (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_btn   (btn[gi]),
         .o_db    (btn_db[gi]),
         .o_pulse (btn_pulse[gi])
      );
   end

   // Highest set pulse wins: N > W > S > E.
   always_comb begin
      w_code = BTN_E;
      if (btn_pulse[3]) begin
         w_code = BTN_N;
      end else if (btn_pulse[2]) begin
         w_code = BTN_W;
      end else if (btn_pulse[1]) begin
         w_code = BTN_S;
      end
   end

   assign w_any_pulse = |btn_pulse;

`ifdef BTN_MULTI_REJECT_EN
   logic r_multi;

   // Two or more pulses together, or a pulse while another button is already held.
   assign w_reject = (|(btn_pulse & (btn_pulse - 4'd1))) ||
                     (w_any_pulse && (|(btn_db & ~btn_pulse)));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_multi <= 1'b0;
      end else begin
         r_multi <= w_reject;
      end
   end

   assign multi_err = r_multi;
`else
   assign w_reject  = 1'b0;
   assign multi_err = 1'b0;
`endif

   assign w_accept = w_any_pulse && !w_reject;

   // Code holds its last accepted value between events.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_code  <= 2'd0;
      end else begin
         r_valid <= w_accept;
         if (w_accept) begin
            r_code <= w_code;
         end
      end
   end

   assign btn_valid = r_valid;
   assign btn_code  = r_code;

endmodule
